soc_dbg_master: RTL
===================

SOC_DBG_MASTER -- requirements
Module: soc_dbg_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning bus wait-cycle limit (used only with SOC_DBG_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_vld  input  1  command byte valid.
REQ-005 SHALL have port in_dat  input  8  command byte.
REQ-006 SHALL have port in_rdy  output  1  command byte accepted when in_vld&in_rdy.
REQ-007 SHALL have port out_vld  output  1  response byte valid.
REQ-008 SHALL have port out_dat  output  8  response byte.
REQ-009 SHALL have port out_rdy  input  1  response byte consumed when out_vld&out_rdy.
REQ-010 SHALL have port bus  soc_if.MST  -  initiator side: drives vld, addr[31:0], we[3:0], wdat[31:0]; samples rdy, rdat[31:0].

Function
REQ-011 SHALL parse frames: 0x57 + 4 addr bytes + 4 data bytes = write; 0x52 + 4 addr bytes = read; all multi-byte fields MSB first.
REQ-012 SHALL use FSM states IDLE, ADDR, WDAT, BUS, RESP.
REQ-013 IDLE: accepted 0x57/0x52 -> ADDR; any other byte -> RESP with single response byte 0x3F.
REQ-014 ADDR: after 4th byte -> WDAT for write, BUS for read; WDAT: after 4th byte -> BUS.
REQ-015 in_rdy SHALL be 1 only in IDLE, ADDR, WDAT.
REQ-016 BUS: drive bus.vld=1, addr, wdat, we=4'hF (write) or 4'h0 (read); all held stable until bus.vld&bus.rdy.
REQ-017 Completion cycle (vld&rdy): deassert vld next cycle; for read capture bus.rdat that cycle; -> RESP.
REQ-018 bus.vld SHALL be asserted no earlier than the cycle after the last frame byte is accepted (1-cycle minimum latency).
REQ-019 RESP: write -> 1 byte 0x4B; read -> 4 bytes rdat MSB first; advance only on out_vld&out_rdy; after last byte -> IDLE.
REQ-020 out_vld SHALL be 1 only in RESP; out_dat stable while out_vld&!out_rdy.
REQ-021 Byte counter 2 bits, wraps 3->0 on field end; no back-to-back frame acceptance while in BUS/RESP.
REQ-022 bus.rdy asserted in same cycle vld first rises SHALL complete in that cycle (zero wait).
REQ-023 bus.rdy while bus.vld=0 SHALL be ignored.

Reset
REQ-024 On rst=1 at clock edge: state IDLE, counter 0, in_rdy=1 next cycle, out_vld=0, bus.vld=0, bus.we=0, bus.addr=0, bus.wdat=0, out_dat=0.
REQ-025 rst mid-frame or mid-BUS SHALL abandon frame and transaction without response; bus.vld drops the cycle after rst.
REQ-026 rst SHALL take priority over all simultaneous in/out/bus handshakes.

Configuration
REQ-027 Macro SOC_DBG_TIMEOUT_EN defined: wait counter increments each BUS cycle with vld&!rdy; reaching TIMEOUT_CYC drops bus.vld next cycle, returns single byte 0x54 (read or write), -> IDLE after sent; rdy in the timeout cycle itself completes normally (rdy wins).
REQ-028 Macro SOC_DBG_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for rdy.

Verification
REQ-029 Write: bytes 57 10 00 00 04 DE AD BE EF, rdy=1 -> one bus cycle addr=0x1000_0004 we=F wdat=0xDEADBEEF, response 0x4B.
REQ-030 Read with 3 wait cycles: 52 20 00 00 08, rdat=0x12345678 on rdy -> vld high 4 cycles, addr stable, response 12 34 56 78.
REQ-031 Bad opcode 0xAA, then valid read -> response 0x3F, then correct read response; no bus activity for 0xAA.
REQ-032 out_rdy held 0 for 5 cycles during read response -> out_dat held 0x12, in_rdy=0, no byte lost.
REQ-033 rst pulsed during BUS wait -> bus.vld=0 cycle after rst, no response, next frame processed normally.
REQ-034 With SOC_DBG_TIMEOUT_EN, TIMEOUT_CYC=16, rdy never asserted -> vld drops after 16 wait cycles, response 0x54.

Source files
------------

// File: rtl/soc_dbg_master_if.sv
// soc_if -- simple valid/ready memory-mapped bus between a debug master and
// a target.
//
// Signals
//   vld   initiator request valid; request fields held until vld&rdy
//   addr  32-bit byte address
//   we    byte write enables; 4'hF = full-word write, 4'h0 = read
//   wdat  32-bit write data
//   rdy   target completes the request in a cycle where vld is also high
//   rdat  32-bit read data, valid in the completion cycle
//
// Modports: MST (initiator), SLV (target).
interface soc_if;
  logic        vld;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdat;
  logic        rdy;
  logic [31:0] rdat;

  modport MST (output vld, addr, we, wdat, input rdy, rdat);
  modport SLV (input vld, addr, we, wdat, output rdy, rdat);
endinterface

// File: rtl/soc_dbg_master.sv
// soc_dbg_master -- byte-stream debug command parser that issues single
// 32-bit bus transactions and returns a byte-stream response.
//
// Frames (multi-byte fields MSB first):
//   0x57 A3 A2 A1 A0 D3 D2 D1 D0  -> write, response 0x4B
//   0x52 A3 A2 A1 A0              -> read,  response R3 R2 R1 R0
//   any other first byte          -> response 0x3F, no bus activity
//
// Ports
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   in_vld   / in_dat  / in_rdy   command byte stream (sink)
//   out_vld  / out_dat / out_rdy  response byte stream (source)
//   bus      soc_if.MST initiator port
//
// Optional feature: define SOC_DBG_TIMEOUT_EN to bound the bus wait. After
// TIMEOUT_CYC wait cycles without rdy the request is dropped and a single
// 0x54 byte is returned. Without the macro the bus waits forever.
module soc_dbg_master #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [7:0] in_dat,
  output logic       in_rdy,
  output logic       out_vld,
  output logic [7:0] out_dat,
  input  logic       out_rdy,
  soc_if.MST         bus
);

  typedef enum logic [2:0] {IDLE, ADDR, WDAT, BUS, RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        isWr_q, isWr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  // Response bytes are shifted out of the top byte; respLeft counts the
  // bytes still to follow the one currently presented.
  logic [31:0] resp_q, resp_d;
  logic [1:0]  respLeft_q, respLeft_d;
  logic        accept;

`ifdef SOC_DBG_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_CYC + 1);
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      isWr_q     <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      resp_q     <= '0;
      respLeft_q <= '0;
`ifdef SOC_DBG_TIMEOUT_EN
      waitCnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isWr_q     <= isWr_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      resp_q     <= resp_d;
      respLeft_q <= respLeft_d;
`ifdef SOC_DBG_TIMEOUT_EN
      waitCnt_q  <= waitCnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isWr_d     = isWr_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    resp_d     = resp_q;
    respLeft_d = respLeft_q;
`ifdef SOC_DBG_TIMEOUT_EN
    waitCnt_d  = '0;
`endif

    in_rdy   = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDAT);
    out_vld  = (state_q == RESP);
    out_dat  = resp_q[31:24];
    // vld comes straight from the state register, so it can rise no earlier
    // than the cycle after the last frame byte was accepted.
    bus.vld  = (state_q == BUS);
    bus.addr = addr_q;
    bus.wdat = wdat_q;
    bus.we   = ((state_q == BUS) && isWr_q) ? 4'hF : 4'h0;
    accept   = in_vld && in_rdy;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (in_dat == 8'h57 || in_dat == 8'h52) begin
            isWr_d  = (in_dat == 8'h57);
            addr_d  = '0;
            wdat_d  = '0;
            state_d = ADDR;
          end else begin
            resp_d     = {8'h3F, 24'h0};
            respLeft_d = 2'd0;
            state_d    = RESP;
          end
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d = {addr_q[23:0], in_dat};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = isWr_q ? WDAT : BUS;
        end
      end
      WDAT: begin
        if (accept) begin
          wdat_d = {wdat_q[23:0], in_dat};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = BUS;
        end
      end
      BUS: begin
        // rdy is checked first so a completion in the timeout cycle wins.
        if (bus.rdy) begin
          resp_d     = isWr_q ? {8'h4B, 24'h0} : bus.rdat;
          respLeft_d = isWr_q ? 2'd0 : 2'd3;
          state_d    = RESP;
        end
`ifdef SOC_DBG_TIMEOUT_EN
        else if (waitCnt_q == WCW'(TIMEOUT_CYC - 1)) begin
          resp_d     = {8'h54, 24'h0};
          respLeft_d = 2'd0;
          state_d    = RESP;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (out_rdy) begin
          resp_d = {resp_q[23:0], 8'h00};
          if (respLeft_q == 2'd0) state_d = IDLE;
          else respLeft_d = respLeft_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
